// File: rtl/z80_bus_responder_if.sv
// rtl/z80_bus_responder_if.sv - Z80 CPU bus and host preload port bundle
interface z80_bus_responder_if;

    // CPU address/data and strobes (strobes active-low)
    logic [15:0] A;
    logic [7:0]  dout;
    logic [7:0]  di;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic        wait_n;

    // Host preload port
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;

    // CPU model / host side
    modport master (
        output A, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        output host_we, host_addr, host_wdata,
        input  di, wait_n, host_ack
    );

    // Responder side
    modport slave (
        input  A, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        input  host_we, host_addr, host_wdata,
        output di, wait_n, host_ack
    );

endinterface

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - Z80 memory/IO/interrupt-ack bus responder; optional wait states via Z80_BUS_RESP_WAIT_EN
module z80_bus_responder #(
    parameter int         MEM_AW      = 16,
    parameter int         WAIT_STATES = 2,
    parameter logic [7:0] INT_VECTOR  = 8'hFF
) (
    input logic            clk,
    input logic            reset,
    z80_bus_responder_if.slave bus
);

    // Reject out-of-range wait counts at elaboration; cnt is 4 bits wide.
    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("z80_bus_responder: WAIT_STATES must be 1..15");
    end

`ifdef Z80_BUS_RESP_WAIT_EN
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACTIVE,
        DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;
`endif

    // Which target the current access addresses, captured at access start
    typedef enum logic [1:0] {
        K_MEM,
        K_IO,
        K_INTA
    } kind_t;

    state_t      state;
    kind_t       kind;
    logic        is_write;
    logic [7:0]  di_q;
    logic        host_ack_q;
`ifdef Z80_BUS_RESP_WAIT_EN
    logic [3:0]  cnt;
    logic        wait_q;
`endif

    logic [7:0]  mem [0:(1 << MEM_AW) - 1];
    logic [7:0]  io  [0:255];

    // Bus decode
    logic              mem_start;
    logic              io_start;
    logic              inta_start;
    logic              any_start;
    logic              host_go;
    logic              release_ok;
    logic              cpu_wr;
    logic              mem_we;
    logic              io_we;
    logic [MEM_AW-1:0] cpu_addr;
    logic [MEM_AW-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              unused_hi;

    // Upper address bits alias onto the array and are deliberately dropped.
    assign unused_hi = ^{bus.A, bus.host_addr};

    assign cpu_addr = bus.A[MEM_AW-1:0];

    // Refresh cycles fail mem_start because rfsh_n is low, so they are ignored.
    assign mem_start  = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);
    assign io_start   = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n);
    assign inta_start = !bus.iorq_n && !bus.m1_n;
    assign any_start  = (state == IDLE) && (mem_start || io_start || inta_start);

    // The CPU wins over the host; host_we stays pending until a quiet IDLE clock.
    assign host_go    = (state == IDLE) && !(mem_start || io_start || inta_start)
                        && bus.host_we;

    assign release_ok = (bus.mreq_n && bus.iorq_n) || (bus.rd_n && bus.wr_n && bus.m1_n);

    // ACTIVE lasts exactly one clock, so each CPU write lands once.
    assign cpu_wr     = (state == ACTIVE) && is_write;
    assign io_we      = cpu_wr && (kind == K_IO);
    assign mem_we     = (cpu_wr && (kind == K_MEM)) || host_go;
    assign mem_waddr  = host_go ? bus.host_addr[MEM_AW-1:0] : cpu_addr;
    assign mem_wdata  = host_go ? bus.host_wdata : bus.dout;

    // Array write ports; arrays carry no reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (io_we) begin
            io[bus.A[7:0]] <= bus.dout;
        end
    end

    // Access sequencer with registered di, wait_n and host_ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            kind       <= K_MEM;
            is_write   <= 1'b0;
            di_q       <= 8'hFF;
            host_ack_q <= 1'b0;
`ifdef Z80_BUS_RESP_WAIT_EN
            cnt        <= 4'd0;
            wait_q     <= 1'b1;
`endif
        end else begin
            host_ack_q <= host_go;
            case (state)
                IDLE: begin
                    if (any_start) begin
                        if (mem_start) begin
                            kind <= K_MEM;
                        end else if (inta_start) begin
                            kind <= K_INTA;
                        end else begin
                            kind <= K_IO;
                        end
                        // rd_n and wr_n both low resolves to a write
                        is_write <= !bus.wr_n && !inta_start;
`ifdef Z80_BUS_RESP_WAIT_EN
                        state  <= WAIT;
                        cnt    <= 4'(WAIT_STATES);
                        wait_q <= 1'b0;
`else
                        state  <= ACTIVE;
`endif
                    end
                end
`ifdef Z80_BUS_RESP_WAIT_EN
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state  <= ACTIVE;
                        cnt    <= 4'd0;
                        wait_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`endif
                ACTIVE: begin
                    if (!is_write) begin
                        case (kind)
                            K_MEM:   di_q <= mem[cpu_addr];
                            K_IO:    di_q <= io[bus.A[7:0]];
                            default: di_q <= INT_VECTOR;
                        endcase
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (release_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.di       = di_q;
    assign bus.host_ack = host_ack_q;
`ifdef Z80_BUS_RESP_WAIT_EN
    assign bus.wait_n   = wait_q;
`else
    assign bus.wait_n   = 1'b1;
`endif

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 Parameter MEM_AW, default 16: memory address width; memory depth is 2**MEM_AW bytes, indexed by A[MEM_AW-1:0].
REQ-002 Parameter WAIT_STATES, default 2, range 1..15: number of clocks wait_n is held low per access.
REQ-003 Parameter INT_VECTOR, default 8'hFF: byte returned on an interrupt-acknowledge cycle.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 A  input  16  CPU address bus.
REQ-007 dout  input  8  CPU write data.
REQ-008 di  output  8  read data to the CPU.
REQ-009 m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  input  1 each  CPU bus strobes, active-low.
REQ-010 wait_n  output  1  wait request to the CPU, active-low.
REQ-011 host_we  input  1  host preload write request.
REQ-012 host_addr  input  16  host preload address.
REQ-013 host_wdata  input  8  host preload data.
REQ-014 host_ack  output  1  one-clock pulse when a host write completes.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, ACTIVE and DONE.
REQ-016 Access start: the block SHALL detect one of the following in IDLE:
- mem read/write: !mreq_n & rfsh_n & (!rd_n | !wr_n);
- IO read/write: !iorq_n & m1_n & (!rd_n | !wr_n);
- interrupt acknowledge: !iorq_n & !m1_n.
REQ-017 A refresh cycle (!mreq_n & !rfsh_n) SHALL be ignored: no state change, no memory access, wait_n stays 1.
REQ-018 IDLE -> WAIT on access start; load cnt=WAIT_STATES and drive wait_n=0 from the next edge.
REQ-019 In WAIT, cnt SHALL decrement each clock; at cnt==1 go to ACTIVE and release wait_n=1, so wait_n is low for exactly WAIT_STATES clocks.
REQ-020 ACTIVE read SHALL register di from the selected source in one clock:
- mem[A[MEM_AW-1:0]] for memory reads;
- io[A[7:0]] for IO reads;
- INT_VECTOR for interrupt acknowledge.
REQ-021 ACTIVE write SHALL store dout exactly once per access:
- memory writes to mem[A[MEM_AW-1:0]];
- IO writes to io[A[7:0]].
- A[15:8] is ignored for IO.
REQ-022 ACTIVE -> DONE unconditionally; di SHALL hold its value through DONE.
REQ-023 DONE -> IDLE when (mreq_n & iorq_n) or (rd_n & wr_n & m1_n); no new access SHALL start until IDLE is re-entered.
REQ-024 If rd_n and wr_n are both low at access start, the access SHALL be treated as a write.
REQ-025 Host write SHALL execute only in IDLE with no CPU access start that clock:
- it writes mem[host_addr] = host_wdata;
- host_ack pulses high the following clock.
REQ-026 On simultaneous CPU access start and host_we, the CPU SHALL win; host_we SHALL remain pending (the host holds it) until serviced.
REQ-027 Address bits above MEM_AW SHALL alias (wrap) onto the memory array.
REQ-028 di SHALL be 8'hFF whenever no read has completed since reset.

Reset
REQ-029 Reset SHALL force, asynchronously: state=IDLE, wait_n=1, di=8'hFF, host_ack=0, cnt=0.
REQ-030 Reset mid-access, in any state, SHALL abort without a memory or IO write; array contents SHALL be retained.

Configuration
REQ-031 Macro Z80_BUS_RESP_WAIT_EN defined: WAIT state and WAIT_STATES behave as in REQ-018/019.
REQ-032 Macro Z80_BUS_RESP_WAIT_EN undefined:
- wait_n SHALL be constant 1 and the WAIT state and cnt SHALL be absent;
- IDLE SHALL go directly to ACTIVE;
- WAIT_STATES SHALL be ignored.

Verification
REQ-033 Scenario 1, host preload and memory read:
- host preload mem[0x155D]=0xB9, host_ack seen;
- then mreq_n=0, rd_n=0, A=0x155D -> wait_n low exactly 2 clocks, then di=0xB9 held until strobes release.
REQ-034 Scenario 2, memory write then read-back:
- write A=0x155D, dout=0x5A with mreq_n=0, wr_n=0 held 6 clocks -> single write;
- subsequent read returns 0x5A.
REQ-035 Scenario 3, IO write then read:
- IO write A=0xAB47, dout=0x10;
- IO read A=0x0047 -> di=0x10.
REQ-036 Scenario 4, refresh cycle:
- mreq_n=0, rfsh_n=0, A=0x0002 -> FSM stays IDLE, wait_n=1, di unchanged.
REQ-037 Scenario 5, interrupt acknowledge and host collision:
- m1_n=0, iorq_n=0 -> di=0xFF (INT_VECTOR);
- host_we asserted the same clock -> host_ack only after DONE->IDLE.
REQ-038 Scenario 6, reset during WAIT:
- reset asserted mid-WAIT during a write to 0x1000 -> wait_n=1 immediately, state IDLE, mem[0x1000] unchanged;
- with the macro undefined, scenario 1 shows wait_n never low.
